memu: RTL
=========

Name: memu

Overview:
- Memory-access pipeline stage between the execute stage and the write-back stage.
- Accepts one instruction per valid/ready handshake from execute. Issues at most one load or store on a req/resp data-memory port, and aligns and extends load data.
- Presents {regData, regAddr, regW} to write-back over the same valid/ready handshake write-back already uses.
- Holds exactly one instruction in flight.

Parameters:
- REG_ADDR_WIDTH, 5, register-file address width.
- DATA_WIDTH, 32, datapath width. Lane logic is defined for 32 only; any other value is unsupported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- ex_to_mem_valid  input  1  execute holds a valid instruction.
- mem_to_ex_ready  output  1  this stage can accept this cycle.
- ex_to_mem_bus  input  2*DATA_WIDTH+REG_ADDR_WIDTH+6  fields, LSB first:
  - [0] regW
  - [REG_ADDR_WIDTH:1] regAddr
  - [+1] memRen
  - [+2] memWen
  - [+3..+5] funct3
  - next DATA_WIDTH bits: aluResult (also the memory address)
  - top DATA_WIDTH bits: memWdata
- mem_to_wb_valid  output  1  result valid to write-back.
- wb_to_mem_ready  input  1  write-back can accept.
- mem_to_wb_bus  output  DATA_WIDTH+REG_ADDR_WIDTH+1  {regData, regAddr, regW}, regW at bit 0.
- data_req_valid  output  1  memory request valid.
- data_req_ready  input  1  memory accepts request.
- data_req_wen  output  1  1 = store, 0 = load.
- data_req_addr  output  DATA_WIDTH  byte address (aluResult, unmodified).
- data_req_wdata  output  DATA_WIDTH  store data replicated onto lanes.
- data_req_wstrb  output  DATA_WIDTH/8  byte-write strobes.
- data_resp_valid  input  1  response valid (load data or store ack).
- data_resp_ready  output  1  stage accepts response.
- data_resp_rdata  input  DATA_WIDTH  load data, full aligned word.

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE.
- Reset (rst=0, asynchronous):
  - state=IDLE; all latched fields cleared.
  - Outputs: mem_to_ex_ready=1, mem_to_wb_valid=0, data_req_valid=0, data_resp_ready=0.
  - Reset mid-transaction abandons the access; a late data_resp_valid is ignored because data_resp_ready=0 in IDLE.
- mem_to_ex_ready = (state==IDLE) || (state==DONE && wb_to_mem_ready).
- Accept: ex_to_mem_valid && mem_to_ex_ready latches all bus fields.
  - Next state = REQ if memRen|memWen, else DONE with regData=aluResult.
  - Accepting in DONE while write-back drains gives back-to-back flow with no bubble.
- Access type: memRen && memWen is treated as a store.
- REQ:
  - data_req_valid=1; all data_req_* fields come from latched registers and stay stable until the handshake.
  - On data_req_ready -> RESP.
- RESP:
  - data_resp_ready=1. The response arrives no earlier than the cycle after the request handshake.
  - On data_resp_valid -> DONE. Load: regData = extended data. Store: regData = aluResult.
- DONE:
  - mem_to_wb_valid=1 and mem_to_wb_bus is held stable.
  - On wb_to_mem_ready: -> IDLE, or re-enter per the accept rule if a new instruction is accepted the same cycle.
- Lane rules, with off = addr[1:0]:
  - Store wdata: SB = byte replicated x4; SH = half replicated x2; SW = word.
  - Store wstrb: SB = 0001<<off; SH = 0011<<off; SW = 1111.
  - Load: shifted = rdata >> (8*off).
    - LB (000) / LBU (100): sign- / zero-extend shifted[7:0].
    - LH (001) / LHU (101): sign- / zero-extend shifted[15:0].
    - LW (010): full word.
  - Misalignment is not checked; an SH at off=3 or an SW at off!=0 is undefined.
  - Loads drive wstrb=0000.
  - Other funct3 codes behave as LW/SW.
- Latency, from acceptance in cycle N:
  - Non-memory instruction: mem_to_wb_valid at N+1.
  - Memory access with req_ready=1 and a 1-cycle response: mem_to_wb_valid at N+3.
  - Each stall cycle on data_req_ready, data_resp_valid or wb_to_mem_ready adds one cycle.
- Stores with regW=1 write aluResult; regW is passed through unmodified.

Test Plan:
- Reset: rst=0 asynchronously mid-REQ -> data_req_valid drops the same cycle; after release mem_to_ex_ready=1 and mem_to_wb_valid=0.
- ALU pass-through: aluResult=0x1234_5678, regAddr=5, regW=1, no mem op -> next cycle mem_to_wb_bus={0x12345678,5,1}, valid=1; back-to-back stream with wb_to_mem_ready=1 gives one result per cycle.
- Load extension at addr 0x1003 with rdata=0x80FF_7F01:
  - LB -> 0xFFFF_FF80.
  - LBU -> 0x0000_0080.
- Halfword loads at addr 0x1002 with rdata=0x80FF_7F01:
  - LH -> 0xFFFF_80FF.
  - LHU -> 0x0000_80FF.
- Store: SB at addr 0x2001, wdata=0xAB -> data_req_wen=1, wstrb=0010, wdata=0xABAB_ABAB; result held until the ack, then regW=0 forwarded.
- Backpressure: data_req_ready low 3 cycles, response 2 cycles late, wb_to_mem_ready low 2 cycles:
  - req fields stable throughout; mem_to_ex_ready=0 until DONE and write-back ready; mem_to_wb_bus unchanged while stalled.

Source files
------------

// File: rtl/memu.sv
// memu: memory-access stage between execute and write-back.
// One instruction in flight; aligns store lanes and extends load data.
module memu #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   ex_to_mem_valid,
  output logic                                   mem_to_ex_ready,
  input  logic [2*DATA_WIDTH+REG_ADDR_WIDTH+5:0] ex_to_mem_bus,
  output logic                                   mem_to_wb_valid,
  input  logic                                   wb_to_mem_ready,
  output logic [DATA_WIDTH+REG_ADDR_WIDTH:0]     mem_to_wb_bus,
  output logic                                   data_req_valid,
  input  logic                                   data_req_ready,
  output logic                                   data_req_wen,
  output logic [DATA_WIDTH-1:0]                  data_req_addr,
  output logic [DATA_WIDTH-1:0]                  data_req_wdata,
  output logic [DATA_WIDTH/8-1:0]                data_req_wstrb,
  input  logic                                   data_resp_valid,
  output logic                                   data_resp_ready,
  input  logic [DATA_WIDTH-1:0]                  data_resp_rdata
);
  localparam int RA = REG_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e          state_q, state_d;
  logic            regw_q, regw_d;
  logic [RA-1:0]   rd_q, rd_d;
  logic            wen_q, wen_d;
  logic [2:0]      f3_q, f3_d;
  logic [DW-1:0]   alu_q, alu_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [DW-1:0]   res_q, res_d;

  logic            in_regw, in_ren, in_wen;
  logic [RA-1:0]   in_rd;
  logic [2:0]      in_f3;
  logic [DW-1:0]   in_alu, in_wdat;
  logic            accept;
  logic [1:0]      off;
  logic [DW-1:0]   shifted, ld_data;

  assign in_regw = ex_to_mem_bus[0];
  assign in_rd   = ex_to_mem_bus[RA:1];
  assign in_ren  = ex_to_mem_bus[RA+1];
  assign in_wen  = ex_to_mem_bus[RA+2];
  assign in_f3   = ex_to_mem_bus[RA+5:RA+3];
  assign in_alu  = ex_to_mem_bus[RA+6 +: DW];
  assign in_wdat = ex_to_mem_bus[RA+6+DW +: DW];

  assign mem_to_ex_ready = (state_q == IDLE) ||
                           (state_q == DONE && wb_to_mem_ready);
  assign accept          = ex_to_mem_valid && mem_to_ex_ready;

  assign mem_to_wb_valid = (state_q == DONE);
  assign mem_to_wb_bus   = {res_q, rd_q, regw_q};
  assign data_req_valid  = (state_q == REQ);
  assign data_resp_ready = (state_q == RESP);
  assign data_req_wen    = wen_q;
  assign data_req_addr   = alu_q;
  assign off             = alu_q[1:0];

  always_comb begin
    data_req_wdata = wdat_q;
    data_req_wstrb = 4'b1111;
    unique case (f3_q)
      3'b000: begin
        data_req_wdata = {4{wdat_q[7:0]}};
        data_req_wstrb = 4'b0001 << off;
      end
      3'b001: begin
        data_req_wdata = {2{wdat_q[15:0]}};
        data_req_wstrb = 4'b0011 << off;
      end
      default: ;
    endcase
    if (!wen_q) data_req_wstrb = '0;
  end

  always_comb begin
    shifted = data_resp_rdata >> {off, 3'b000};
    unique case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = data_resp_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    regw_d  = regw_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    f3_d    = f3_q;
    alu_d   = alu_q;
    wdat_d  = wdat_q;
    res_d   = res_q;
    unique case (state_q)
      REQ:  if (data_req_ready) state_d = RESP;
      RESP: if (data_resp_valid) begin
        state_d = DONE;
        res_d   = wen_q ? alu_q : ld_data;
      end
      DONE: if (wb_to_mem_ready) state_d = IDLE;
      default: ;
    endcase
    // a new accept overrides the drain of DONE for bubble-free flow
    if (accept) begin
      regw_d  = in_regw;
      rd_d    = in_rd;
      wen_d   = in_wen;
      f3_d    = in_f3;
      alu_d   = in_alu;
      wdat_d  = in_wdat;
      res_d   = in_alu;
      state_d = (in_ren || in_wen) ? REQ : DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      regw_q  <= 1'b0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      f3_q    <= '0;
      alu_q   <= '0;
      wdat_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      regw_q  <= regw_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      f3_q    <= f3_d;
      alu_q   <= alu_d;
      wdat_q  <= wdat_d;
      res_q   <= res_d;
    end
  end

endmodule
